nvram_uploader: RTL
===================

NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, meaning CMOS NVRAM address width (2^ADDR_W nibbles).
REQ-002 SHALL provide parameter NV_INDEX, default 8'd4, meaning the ioctl_index value that selects the NVRAM upload.
REQ-003 SHALL provide parameter RD_LAT, default 1, range 1..4, meaning the number of clk_sys cycles from ram_rd to valid ram_q.
REQ-004 SHALL provide port clk_sys, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL provide port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL provide port ioctl_upload, input, 1 bit: HPS upload session active.
REQ-007 SHALL provide port ioctl_index, input, 8 bits: upload target index.
REQ-008 SHALL provide port ioctl_rd, input, 1 bit: one-cycle byte read strobe from HPS.
REQ-009 SHALL provide port ioctl_addr, input, 17 bits: byte address of the read.
REQ-010 SHALL provide port ioctl_din, output, 8 bits: byte returned to HPS.
REQ-011 SHALL provide port ioctl_wait, output, 1 bit: HPS stall while a read is in progress.
REQ-012 SHALL provide port ioctl_upload_req, output, 1 bit: one-cycle request to HPS to start a save.
REQ-013 SHALL provide port save_req, input, 1 bit: OSD save command, level, edge-detected internally.
REQ-014 SHALL provide port cmos_we, input, 1 bit: CPU write to CMOS this cycle.
REQ-015 SHALL provide port ram_addr, output, ADDR_W bits: NVRAM read port address.
REQ-016 SHALL provide port ram_rd, output, 1 bit: NVRAM read enable.
REQ-017 SHALL provide port ram_q, input, 4 bits: NVRAM read data.

Function
REQ-018 SHALL define "match" as ioctl_upload=1 and ioctl_index=NV_INDEX.
REQ-019 SHALL implement the FSM states IDLE, FETCH, LAT and PRESENT.
REQ-020 In IDLE, ioctl_rd with match and ioctl_addr < 2^ADDR_W SHALL latch ioctl_addr[ADDR_W-1:0] into ram_addr and go to FETCH.
REQ-021 In IDLE, ioctl_rd with match and ioctl_addr >= 2^ADDR_W SHALL set ioctl_din=8'hFF, go directly to PRESENT and issue no ram_rd.
REQ-022 In FETCH, the block SHALL assert ram_rd for exactly one cycle, load the latency counter with RD_LAT-1 and go to LAT.
REQ-023 In LAT, the block SHALL decrement the counter; at 0 it SHALL register ioctl_din={4'hF, ram_q} and go to PRESENT.
REQ-024 In PRESENT, the block SHALL hold ioctl_din and return to IDLE on the next cycle.
REQ-025 ioctl_wait SHALL be combinational: (state != IDLE and state != PRESENT) or (state == IDLE and ioctl_rd and match).
REQ-026 Latency: ioctl_rd at cycle 0 -> ram_rd at cycle 1 -> ioctl_din valid and ioctl_wait=0 from cycle RD_LAT+2.
REQ-027 ioctl_rd while the FSM is not in IDLE SHALL be ignored.
REQ-028 ioctl_rd without match SHALL be ignored, with no wait and no ram_rd.
REQ-029 ioctl_upload falling while the FSM is not in IDLE SHALL abort to IDLE next cycle, with ram_rd and ioctl_wait low and ioctl_din unchanged.
REQ-030 ram_addr SHALL hold its last value outside FETCH.
REQ-031 The dirty flag SHALL be set on any cycle with cmos_we=1.
REQ-032 The "complete" flag SHALL be set when a matched read of address 2^ADDR_W-1 finishes PRESENT, and cleared at the start of each matched session (rising edge of match).
REQ-033 On the falling edge of match with complete=1, dirty SHALL clear unless cmos_we=1 in the same cycle, in which case dirty stays 1.
REQ-034 A rising edge of save_req with dirty=1 and ioctl_upload=0 SHALL pulse ioctl_upload_req for exactly one cycle.
REQ-035 A rising edge of save_req otherwise SHALL be dropped, not queued.

Reset
REQ-036 reset_n=0 sampled at a clk_sys edge SHALL force, next cycle: state=IDLE, ioctl_din=8'h00, ioctl_wait=0 (unless a matched ioctl_rd is present), ram_rd=0, ram_addr=0, ioctl_upload_req=0, dirty=0, complete=0, and the edge-detect registers equal to the current inputs.
REQ-037 Reset asserted mid-read SHALL abandon the read with no further ram_rd.

Verification
REQ-038 Basic read, RD_LAT=1: match, ioctl_rd with addr=0x005, ram_q=4'h7 -> ram_rd at cycle 1 with ram_addr=0x005; ioctl_din=8'hF7 and wait=0 at cycle 3.
REQ-039 Out-of-range read: addr=0x00400 -> ioctl_din=8'hFF, no ram_rd, wait high for cycle 0 only.
REQ-040 Save request: cmos_we pulse, then save_req 0->1 -> ioctl_upload_req high exactly 1 cycle; a second edge with upload=1 -> no pulse.
REQ-041 Full upload: read 0x000..0x3FF then drop ioctl_upload -> dirty=0; repeat with cmos_we on the drop cycle -> dirty=1.
REQ-042 Abort: RD_LAT=4, drop ioctl_upload during LAT -> IDLE next cycle, wait=0, dirty unchanged.
REQ-043 Reset mid-FETCH: reset_n=0 -> all outputs at REQ-036 values next cycle, no ram_rd.

Source files
------------

// File: rtl/nvram_uploader.sv
// nvram_uploader: serves HPS byte reads of the 4-bit CMOS NVRAM during a
// matched upload session and raises a save request when the NVRAM is dirty.
module nvram_uploader #(
  parameter int          ADDR_W   = 10,
  parameter logic [7:0]  NV_INDEX = 8'd4,
  parameter int          RD_LAT   = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [16:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              save_req,
  input  logic              cmos_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [3:0]        ram_q
);

  typedef enum logic [1:0] {IDLE, FETCH, LAT, PRESENT} state_t;

  // One past the highest NVRAM nibble address, widened so the compare never wraps.
  localparam logic [17:0] NV_SIZE  = 18'd1 << ADDR_W;
  localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [7:0]        din_reg, din_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              last_reg, last_next;
  logic              dirty_reg, dirty_next;
  logic              complete_reg, complete_next;
  logic              upreq_reg, upreq_next;
  logic              match_d_reg, save_d_reg;

  logic match, match_rise, match_fall, save_rise, in_range, addr_is_last;

  assign match        = ioctl_upload && (ioctl_index == NV_INDEX);
  assign match_rise   = match && !match_d_reg;
  assign match_fall   = !match && match_d_reg;
  assign save_rise    = save_req && !save_d_reg;
  assign in_range     = ({1'b0, ioctl_addr} < NV_SIZE);
  assign addr_is_last = (ioctl_addr[ADDR_W-1:0] == {ADDR_W{1'b1}});

  assign ioctl_din        = din_reg;
  assign ram_addr         = addr_reg;
  assign ioctl_upload_req = upreq_reg;

  // Next-state, read handshake outputs and session bookkeeping.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    din_next      = din_reg;
    addr_next     = addr_reg;
    last_next     = last_reg;
    dirty_next    = dirty_reg;
    complete_next = complete_reg;
    upreq_next    = 1'b0;
    ram_rd        = 1'b0;
    ioctl_wait    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ioctl_rd && match) begin
          ioctl_wait = 1'b1;
          if (in_range) begin
            addr_next  = ioctl_addr[ADDR_W-1:0];
            last_next  = addr_is_last;
            state_next = FETCH;
          end else begin
            // Reads past the end of NVRAM return erased-flash style 0xFF.
            din_next   = 8'hFF;
            last_next  = 1'b0;
            state_next = PRESENT;
          end
        end
      end
      FETCH: begin
        ioctl_wait = 1'b1;
        ram_rd     = 1'b1;
        cnt_next   = LAT_INIT;
        state_next = LAT;
      end
      LAT: begin
        ioctl_wait = 1'b1;
        if (cnt_reg == 2'd0) begin
          din_next   = {4'hF, ram_q};
          state_next = PRESENT;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      PRESENT: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // The HPS closing the session mid-read abandons the read; the byte last
    // presented stays on ioctl_din.
    if (state_reg != IDLE && !ioctl_upload) begin
      state_next = IDLE;
      din_next   = din_reg;
    end

    if (match_rise) begin
      complete_next = 1'b0;
    end else if (state_reg == PRESENT && last_reg) begin
      complete_next = 1'b1;
    end

    // A CPU write on the very cycle the session closes must not be lost.
    if (cmos_we) begin
      dirty_next = 1'b1;
    end else if (match_fall && complete_reg) begin
      dirty_next = 1'b0;
    end

    upreq_next = save_rise && dirty_reg && !ioctl_upload;
  end

  // State register; edge detectors track the live inputs even in reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      din_reg      <= 8'h00;
      addr_reg     <= '0;
      last_reg     <= 1'b0;
      dirty_reg    <= 1'b0;
      complete_reg <= 1'b0;
      upreq_reg    <= 1'b0;
      match_d_reg  <= match;
      save_d_reg   <= save_req;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      din_reg      <= din_next;
      addr_reg     <= addr_next;
      last_reg     <= last_next;
      dirty_reg    <= dirty_next;
      complete_reg <= complete_next;
      upreq_reg    <= upreq_next;
      match_d_reg  <= match;
      save_d_reg   <= save_req;
    end
  end

endmodule
